// File: rtl/odd_parity_frame_tx_if.sv
// Payload handshake and serial transmit signals of odd_parity_frame_tx.
// master: payload source and serial sink; slave: the transmitter.
interface odd_parity_frame_tx_if;
   logic        in_valid;
   logic [14:0] in_data;
   logic        in_ready;
   logic        tx_bit;
   logic        tx_valid;
   logic        tx_sof;
   logic        busy;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  tx_bit,
      input  tx_valid,
      input  tx_sof,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output tx_bit,
      output tx_valid,
      output tx_sof,
      output busy
   );
endinterface

// File: rtl/odd_parity_frame_tx.sv
// Serial transmitter for 16-bit odd-position-parity frames, LSB first.
// Define PTX_BURST_EN to allow back-to-back frames (accept on the last shift cycle).
module odd_parity_frame_tx #(
   parameter int unsigned IDLE_GAP = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   odd_parity_frame_tx_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam bit         GAP_EN   = (IDLE_GAP != 0);
   localparam logic [3:0] GAP_LOAD = GAP_EN ? 4'(IDLE_GAP - 1) : 4'd0;

   state_t      state_reg, state_next;
   logic [15:0] shreg_reg, shreg_next;
   logic [3:0]  cnt_reg,   cnt_next;
   logic [3:0]  gap_reg,   gap_next;

   logic [15:0] frame;
   logic        last_bit;
   logic        ready;
   logic        accept;

   // Low payload byte goes to even positions, high seven bits to odd positions.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_even
         assign frame[2*gi] = bus.in_data[gi];
      end
      for (gi = 0; gi < 7; gi++) begin : g_odd
         assign frame[2*gi+1] = bus.in_data[8+gi];
      end
   endgenerate

   // Makes the ones count over positions 1,3,...,15 odd.
   assign frame[15] = ~^bus.in_data[14:8];

   assign last_bit = (state_reg == ST_SHIFT) && (cnt_reg == 4'd15);

`ifdef PTX_BURST_EN
   assign ready = !rst && ((state_reg == ST_IDLE) || last_bit);
`else
   assign ready = !rst && (state_reg == ST_IDLE);
`endif

   assign accept = ready && bus.in_valid;

   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      gap_next   = gap_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               shreg_next = frame;
               cnt_next   = 4'd0;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shreg_next = {1'b0, shreg_reg[15:1]};
            cnt_next   = cnt_reg + 4'd1;
            if (last_bit) begin
               // An accept here is only possible when burst mode opens in_ready.
               if (accept) begin
                  shreg_next = frame;
                  cnt_next   = 4'd0;
               end else if (GAP_EN) begin
                  state_next = ST_GAP;
                  gap_next   = GAP_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_reg == 4'd0) begin
               state_next = ST_IDLE;
            end else begin
               gap_next = gap_reg - 4'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         shreg_reg <= 16'd0;
         cnt_reg   <= 4'd0;
         gap_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         cnt_reg   <= cnt_next;
         gap_reg   <= gap_next;
      end
   end

   // All serial outputs decode from registered state only.
   assign bus.in_ready = ready;
   assign bus.tx_valid = (state_reg == ST_SHIFT);
   assign bus.tx_bit   = (state_reg == ST_SHIFT) && shreg_reg[0];
   assign bus.tx_sof   = (state_reg == ST_SHIFT) && (cnt_reg == 4'd0);
   assign bus.busy     = (state_reg == ST_SHIFT) || (state_reg == ST_GAP);

endmodule
